// File: rtl/fetch_pkg.sv
// Shared defaults for the instruction-fetch front end.
// The top level takes its parameter defaults from these constants.
package fetch_pkg;

  localparam int FETCH_INSTR_W = 24;
  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_DEPTH   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} words.
// Flush has priority over push/pop. The head reads as zero when the FIFO is empty.
module fetch_fifo #(
  parameter  int W     = 40,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);

  // NOTE: the storage array has no reset; count masks stale entries, so only pointers need one.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one-deep outstanding ROM request
// and a prefetch FIFO with decode stall and branch-redirect flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int                INSTR_W  = FETCH_INSTR_W,
  parameter  int                ADDR_W   = FETCH_ADDR_W,
  parameter  int                DEPTH    = FETCH_DEPTH,
  parameter  logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int                CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pending_pc;
  logic              pending;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    credit_used;
  logic [W-1:0]      head;

  assign out_valid = (occupancy != '0);
  assign pop       = out_valid & ~stall & ~redirect_valid;
  assign push      = pending & ~redirect_valid;

  // Entries held plus the in-flight word, minus what leaves this cycle, must
  // leave room for one more so the returning ROM word always has a slot.
  assign credit_used = {1'b0, occupancy} + (CNT_W+1)'(pending) - (CNT_W+1)'(pop);
  assign issue       = ~redirect_valid & (credit_used < (CNT_W+1)'(DEPTH));

  // NOTE: every register here is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      pending  <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  assign imem_addr = fetch_pc;

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({pending_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (occupancy),
    .head      (head)
  );

  assign out_pc    = head[W-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// stall/redirect run compared each cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int              INSTR_W  = 24;
  localparam int              ADDR_W   = 16;
  localparam int              DEPTH    = 4;
  localparam int              CNT_W    = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               stall;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [CNT_W-1:0]   occupancy;

  int errors = 0;
  int checks = 0;

  entry_t            m_q[$];
  logic [ADDR_W-1:0] m_fetch_pc;
  logic [ADDR_W-1:0] m_pending_pc;
  bit                m_pending;

  fetch_queue #(
    .INSTR_W  (INSTR_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return 24'h100000 + INSTR_W'(a);
  endfunction

  // Synchronous ROM: data for the address of the previous cycle.
  always @(posedge clk) imem_rdata <= rom_word(imem_addr);

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc   = RESET_PC;
    m_pending    = 1'b0;
    m_pending_pc = '0;
  endtask

  task automatic model_edge(input bit st, input bit rv, input logic [ADDR_W-1:0] rpc);
    bit     do_pop;
    bit     do_issue;
    entry_t e;
    if (rv) begin
      m_q.delete();
      m_pending  = 1'b0;
      m_fetch_pc = rpc;
      return;
    end
    do_pop   = (m_q.size() > 0) && !st;
    do_issue = (m_q.size() + int'(m_pending) - int'(do_pop)) < DEPTH;
    if (do_pop) void'(m_q.pop_front());
    if (m_pending) begin
      e.pc    = m_pending_pc;
      e.instr = rom_word(m_pending_pc);
      m_q.push_back(e);
    end
    if (do_issue) begin
      m_pending_pc = m_fetch_pc;
      m_fetch_pc   = m_fetch_pc + 16'd1;
    end
    m_pending = do_issue;
  endtask

  task automatic drive_cycle(input bit st, input bit rv, input logic [ADDR_W-1:0] rpc);
    @(negedge clk);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_edge(st, rv, rpc);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== '0 || out_instr !== '0) begin errors++; $display("FAIL reset_out_data: got pc=%h instr=%h expected 0/0", out_pc, out_instr); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, RESET_PC); end
    @(posedge clk); #2;
    reset = 1'b1;
    model_reset();
    drive_cycle(0, 0, '0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_edge_valid: got %b expected 0", out_valid); end
    drive_cycle(0, 0, '0);
    checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== 24'h100000)
      begin errors++; $display("FAIL first_instr: got v=%b pc=%h instr=%h expected 1/%h/100000", out_valid, out_pc, out_instr, RESET_PC); end
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(0, 0, '0);
      checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC + 16'(i) || out_instr !== 24'h100000 + 24'(i))
        begin errors++; $display("FAIL stream_%0d: got v=%b pc=%h instr=%h expected pc=%h", i, out_valid, out_pc, out_instr, RESET_PC + 16'(i)); end
    end
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] head_pc;
    head_pc = out_pc;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 0, '0);
      checks++; if (out_pc !== head_pc || out_valid !== 1'b1) begin errors++; $display("FAIL stall_frozen_%0d: got pc=%h expected %h", i, out_pc, head_pc); end
      if (i >= 2) begin
        checks++; if (occupancy !== CNT_W'(DEPTH)) begin errors++; $display("FAIL stall_occ_%0d: got %0d expected %0d", i, occupancy, DEPTH); end
        checks++; if (imem_addr !== head_pc + 16'(DEPTH)) begin errors++; $display("FAIL stall_addr_%0d: got %h expected %h", i, imem_addr, head_pc + 16'(DEPTH)); end
      end
    end
    for (int k = 1; k <= 8; k++) begin
      drive_cycle(0, 0, '0);
      checks++; if (out_valid !== 1'b1 || out_pc !== head_pc + 16'(k))
        begin errors++; $display("FAIL unstall_%0d: got v=%b pc=%h expected pc=%h", k, out_valid, out_pc, head_pc + 16'(k)); end
    end
  endtask

  task automatic test_redirect();
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL redirect_pre_occ: got %0d expected 3", occupancy); end
    drive_cycle(0, 1, 16'h0040);
    checks++; if (occupancy !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush: got occ=%0d v=%b expected 0/0", occupancy, out_valid); end
    drive_cycle(0, 0, '0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redirect_t2_valid: got %b expected 0", out_valid); end
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 0, '0);
      checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 + 16'(k) || out_instr !== rom_word(16'h0040 + 16'(k)))
        begin errors++; $display("FAIL redirect_seq_%0d: got v=%b pc=%h instr=%h expected pc=%h", k, out_valid, out_pc, out_instr, 16'h0040 + 16'(k)); end
    end
  endtask

  task automatic test_redirect_stall_full();
    logic [ADDR_W-1:0] rpc;
    rpc = 16'($urandom_range(16'h0100, 16'h7fff));
    for (int i = 0; i < 6; i++) drive_cycle(1, 0, '0);
    checks++; if (occupancy !== CNT_W'(DEPTH)) begin errors++; $display("FAIL full_before_flush: got %0d expected %0d", occupancy, DEPTH); end
    drive_cycle(1, 1, rpc);
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL flush_wins: got occ=%0d expected 0", occupancy); end
    drive_cycle(1, 0, '0);
    drive_cycle(1, 0, '0);
    checks++; if (out_valid !== 1'b1 || out_pc !== rpc) begin errors++; $display("FAIL flush_stall_head: got v=%b pc=%h expected 1/%h", out_valid, out_pc, rpc); end
    drive_cycle(0, 0, '0);
    checks++; if (out_pc !== rpc + 16'd1) begin errors++; $display("FAIL flush_stall_next: got %h expected %h", out_pc, rpc + 16'd1); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_pc [4];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    drive_cycle(0, 1, 16'hFFFE);
    drive_cycle(0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 0, '0);
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k])
        begin errors++; $display("FAIL wrap_%0d: got v=%b pc=%h expected %h", k, out_valid, out_pc, exp_pc[k]); end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 0, '0);
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL async_pre_occ: got %0d expected 2", occupancy); end
    #2;
    reset = 1'b0; stall = 1'b0;
    #1;
    checks++; if (occupancy !== '0 || out_valid !== 1'b0 || out_pc !== '0 || out_instr !== '0)
      begin errors++; $display("FAIL async_clear: got occ=%0d v=%b pc=%h instr=%h expected zeros", occupancy, out_valid, out_pc, out_instr); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL async_addr: got %h expected %h", imem_addr, RESET_PC); end
    @(posedge clk); #2;
    reset = 1'b1;
    model_reset();
    drive_cycle(0, 0, '0);
    drive_cycle(0, 0, '0);
    checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin errors++; $display("FAIL async_restart: got v=%b pc=%h expected 1/%h", out_valid, out_pc, RESET_PC); end
  endtask

  task automatic test_random();
    bit                st;
    bit                rv;
    logic [ADDR_W-1:0] rpc;
    logic [ADDR_W-1:0] exp_pc;
    logic [INSTR_W-1:0] exp_instr;
    for (int n = 0; n < 400; n++) begin
      st  = ($urandom_range(0, 99) < 35);
      rv  = ($urandom_range(0, 99) < 5);
      rpc = 16'($urandom);
      drive_cycle(st, rv, rpc);
      exp_pc    = (m_q.size() > 0) ? m_q[0].pc : '0;
      exp_instr = (m_q.size() > 0) ? m_q[0].instr : '0;
      checks++; if (occupancy !== CNT_W'(m_q.size())) begin errors++; $display("FAIL rand_occ_%0d: got %0d expected %0d", n, occupancy, m_q.size()); end
      checks++; if (out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_valid_%0d: got %b expected %b", n, out_valid, m_q.size() > 0); end
      checks++; if (out_pc !== exp_pc || out_instr !== exp_instr)
        begin errors++; $display("FAIL rand_head_%0d: got pc=%h instr=%h expected pc=%h instr=%h", n, out_pc, out_instr, exp_pc, exp_instr); end
      checks++; if (imem_addr !== m_fetch_pc) begin errors++; $display("FAIL rand_addr_%0d: got %h expected %h", n, imem_addr, m_fetch_pc); end
    end
  endtask

  initial begin
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall_full();
    test_wrap();
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, '0);
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end between the synchronous instruction ROM and the ASIP decode stage. It replaces the single fixed 24-bit ROM-to-decode pipeline register with a PC generator, a one-deep outstanding-request tracker and a DEPTH-entry prefetch FIFO. The FIFO supports decode back-pressure (stall) and branch redirect with flush, and keeps the issue-to-ROM rate at one instruction per cycle when decode is not stalled.

## Interface
Parameters:
- INSTR_W, 24: instruction width.
- ADDR_W, 16: PC / ROM address width.
- DEPTH, 4: prefetch FIFO entries; power of two, ≥ 2.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  single clock; every flop is rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- imem_addr  out  ADDR_W  ROM address; equals fetch_pc.
- imem_rdata  in  INSTR_W  ROM data for the address presented in the previous cycle.
- redirect_valid  in  1  taken branch/jump; flush and restart fetch.
- redirect_pc  in  ADDR_W  restart address; sampled when redirect_valid = 1.
- stall  in  1  decode cannot accept this cycle.
- out_valid  out  1  FIFO head holds an instruction.
- out_instr  out  INSTR_W  head instruction; 0 when empty.
- out_pc  out  ADDR_W  PC of head instruction; 0 when empty.
- occupancy  out  $clog2(DEPTH+1)  entries currently held.

## Operation
- pop = out_valid & ~stall & ~redirect_valid. Decode consumes the head on pop.
- issue = ~redirect_valid & (occupancy + pending − pop < DEPTH). On issue: pending ← 1, pending_pc ← fetch_pc, fetch_pc ← fetch_pc + 1 (modulo 2^ADDR_W, wraps silently). Otherwise pending ← 0.
- push = pending: at the next edge, {pending_pc, imem_rdata} is written to the FIFO tail. With the credit rule, the FIFO cannot overflow.
- Redirect (redirect_valid = 1): at the edge, the FIFO is flushed (occupancy ← 0), pending ← 0 (an in-flight ROM response is discarded), and fetch_pc ← redirect_pc. pop and push are suppressed in that cycle.
- Priority: reset > redirect > push/pop. Simultaneous push and pop leaves occupancy unchanged.
- Stall on an empty FIFO has no effect. Stall never blocks issue while credit remains.

## Timing
- Reset values: fetch_pc = imem_addr = RESET_PC, pending = 0, occupancy = 0, out_valid = 0, out_instr = 0, out_pc = 0.
- ROM latency is exactly 1 cycle. Fetch-to-out_valid is 2 edges: an address issued in cycle T appears at the head in cycle T+2.
- After reset release or a redirect in cycle T, the first instruction is at the head in cycle T+3, with out_pc = RESET_PC or redirect_pc.
- Throughput: 1 instruction/cycle when stall = 0 (holds for DEPTH = 2).
- Stall held for ≥ DEPTH cycles: occupancy saturates at DEPTH, issue stops, and imem_addr holds at head_pc + DEPTH. After stall drops, pops resume the same cycle with no bubble.
- Reset asserted mid-operation clears everything asynchronously. Nothing is re-fetched until the first edge after release.
- Outputs out_* and occupancy are registered or decoded from registered FIFO state only. There is no combinational path from stall/redirect to out_*.

## Structure
- Package fetch_pkg: default constants FETCH_INSTR_W = 24, FETCH_ADDR_W = 16, FETCH_DEPTH = 4. The top level uses these as parameter defaults.
- Sub-module fetch_fifo #(W, DEPTH): synchronous FIFO with push, pop, flush, count and head outputs, and the same async active-low reset. It stores {pc, instr} concatenated, W = ADDR_W + INSTR_W.
- fetch_queue holds fetch_pc, pending, pending_pc and the issue/credit logic, and instantiates fetch_fifo.

## Test plan
- Reset release, RESET_PC = 0, ROM[i] = 0x100000 + i, stall = 0 → out_valid first high in cycle 3 with out_pc = 0 and out_instr = 0x100000. Then consecutive PCs 1, 2, 3… with one instruction per cycle.
- Stall held for 10 cycles after the stream starts → occupancy reaches 4 and stays there; out_pc is frozen; imem_addr holds at head + 4. On release the stream continues with no gaps or duplicates.
- redirect_valid with redirect_pc = 0x0040 in cycle T while occupancy = 3 and pending = 1 → occupancy = 0 at T+1. The in-flight word is never output. The next out_pc is 0x0040, valid at T+3.
- Redirect and stall in the same cycle, FIFO full → flush wins, no pop is counted, and the next head is redirect_pc.
- Redirect to 0xFFFE, no stall → out_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset asserted asynchronously mid-stream with occupancy = 2 → all outputs are 0 and imem_addr = RESET_PC immediately, without waiting for a clock edge.
